// File: rtl/fwpayload_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fwpayload_uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter. Core writes to TXDATA push
//            bytes into a small circular FIFO. A baud-divided shifter
//            serialises them LSB-first onto a single pad.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock    in   1  : only clock
//   reset    in   1  : synchronous, active-high
//   wr_valid in   1  : one-cycle write strobe (already region-qualified)
//   wr_addr  in   2  : 1 = TXDATA, 2 = DIV, 3 = STATUS, 0 ignored
//   wr_data  in  32  : write data
//   rd_addr  in   2  : read select
//   rd_data  out 32  : combinational read data for rd_addr
//   tx       out  1  : registered serial output, idles high
//   tx_oeb   out  1  : pad output enable, active-low, always driven
//   irq      out  1  : high while the FIFO is empty and the shifter is idle
// ============================================================================
module fwpayload_uart_tx #(
  parameter int unsigned          FIFO_DEPTH = 8,
  parameter int unsigned          DIV_WIDTH  = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET  = 16'd867
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        tx_oeb,
  output logic        irq
);

  localparam int unsigned          c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0]   c_ptr_one = 1;
  localparam logic [c_ptr_w:0]     c_cnt_one = 1;
  localparam logic [c_ptr_w:0]     c_depth   = (c_ptr_w + 1)'(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] c_div_one = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w:0]   count_q, count_d;

  // Register file
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 overflow_q, overflow_d;

  // Shifter
  state_t               state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
  logic                 tx_q, tx_d;

  logic full, empty, busy;
  logic wr_txdata, push, pop, bit_end;
  logic unused_wr_data;

  assign full    = (count_q == c_depth);
  assign empty   = (count_q == '0);
  assign busy    = (state_q != S_IDLE);
  assign bit_end = (cnt_q == div_lat_q);

  // Acceptance looks only at the registered count, so a pop in the same
  // cycle never makes room for a push that arrives while full.
  assign wr_txdata = wr_valid && (wr_addr == 2'd1);
  assign push      = wr_txdata && !full;

  // Only some wr_data bits are architecturally meaningful.
  assign unused_wr_data = ^wr_data;

  // --------------------------------------------------------------------------
  // Register writes
  // --------------------------------------------------------------------------
  always_comb begin
    div_d      = div_q;
    overflow_d = overflow_q;
    if (wr_txdata && full) begin
      overflow_d = 1'b1;
    end
    if (wr_valid && (wr_addr == 2'd2)) begin
      div_d = wr_data[DIV_WIDTH-1:0];
    end
    if (wr_valid && (wr_addr == 2'd3) && wr_data[3]) begin
      overflow_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Shifter next-state. Pops only ever happen from IDLE or at the end of
  // STOP, and both are gated on the registered count being non-zero.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          div_lat_d = div_q;
          cnt_d     = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + c_div_one;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + c_div_one;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!empty) begin
            // Chain straight into the next frame with no idle gap.
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            div_lat_d = div_q;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + c_div_one;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // tx is registered, so it is derived from where the FSM is heading.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO pointer / count update
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + c_ptr_one;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      div_q      <= DIV_RESET;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= 3'd0;
      cnt_q      <= '0;
      div_lat_q  <= DIV_RESET;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      div_q      <= div_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      div_lat_q  <= div_lat_d;
      tx_q       <= tx_d;
    end
  end

  // FIFO storage needs no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Read mux and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      2'd1:    rd_data = 32'(count_q);
      2'd2:    rd_data = 32'(div_q);
      2'd3:    rd_data = {28'd0, overflow_q, busy, full, empty};
      default: rd_data = '0;
    endcase
  end

  assign tx     = tx_q;
  assign tx_oeb = 1'b0;
  assign irq    = empty && (state_q == S_IDLE);

endmodule
`default_nettype wire
